// File: rtl/imem_loader.sv
// Boot loader: packs a counted, XOR-checksummed byte stream into 32-bit imem writes and
// holds the core clock-enable low until a complete image has been verified.
module imem_loader #(
    parameter int unsigned IWIDTH   = 32,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned DEPTH    = 1024
) (
    input  logic                il_clk,
    input  logic                il_rst,
    input  logic                il_i_start,
    input  logic                il_i_valid,
    input  logic [7:0]          il_i_byte,
    output logic                il_o_ready,
    output logic                il_o_wr_en,
    output logic [PC_WIDTH-1:0] il_o_addr,
    output logic [IWIDTH-1:0]   il_o_data,
    output logic                il_o_busy,
    output logic                il_o_err,
    output logic                il_o_core_ce
);

    localparam int unsigned IdxW     = $clog2(DEPTH + 1);
    localparam logic [16:0] DepthLim = 17'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                hdr_idx_q, hdr_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [23:0]         shift_q, shift_d;
    logic [7:0]          xor_q, xor_d;
    logic                wr_en_q, wr_en_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [IWIDTH-1:0]   data_q, data_d;

    logic                receiving;
    logic                accept;
    logic [15:0]         hdr_n;
    logic [15:0]         idx_inc;

    assign receiving = (state_q == StHdr) || (state_q == StData) || (state_q == StChk);
    assign accept    = il_i_valid && receiving;
    assign hdr_n     = {cnt_q[15:8], il_i_byte};
    assign idx_inc   = 16'(idx_q) + 16'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_idx_d  = hdr_idx_q;
        byte_idx_d = byte_idx_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        xor_d      = xor_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (il_i_start) begin
                    state_d    = StHdr;
                    cnt_d      = '0;
                    hdr_idx_d  = 1'b0;
                    byte_idx_d = '0;
                    idx_d      = '0;
                    shift_d    = '0;
                    xor_d      = '0;
                end
            end
            StHdr: begin
                if (accept) begin
                    if (!hdr_idx_q) begin
                        cnt_d[15:8] = il_i_byte;
                        hdr_idx_d   = 1'b1;
                    end else begin
                        cnt_d     = hdr_n;
                        hdr_idx_d = 1'b0;
                        if ({1'b0, hdr_n} > DepthLim) begin
                            state_d = StErr;
                        end else if (hdr_n == 16'd0) begin
                            state_d = StChk;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (accept) begin
                    xor_d      = xor_q ^ il_i_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Word complete: the write strobe is registered, so it lands next cycle.
                        wr_en_d = 1'b1;
                        addr_d  = PC_WIDTH'(idx_q) << 2;
                        data_d  = IWIDTH'({shift_q, il_i_byte});
                        idx_d   = idx_q + IdxW'(1);
                        if (idx_inc == cnt_q) begin
                            state_d = StChk;
                        end
                    end else begin
                        shift_d = {shift_q[15:0], il_i_byte};
                    end
                end
            end
            StChk: begin
                if (accept) begin
                    state_d = (il_i_byte == xor_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge il_clk or negedge il_rst) begin
        if (!il_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hdr_idx_q  <= 1'b0;
            byte_idx_q <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            xor_q      <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_idx_q  <= hdr_idx_d;
            byte_idx_q <= byte_idx_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            xor_q      <= xor_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign il_o_ready   = receiving;
    assign il_o_busy    = receiving;
    assign il_o_wr_en   = wr_en_q;
    assign il_o_addr    = addr_q;
    assign il_o_data    = data_q;
    assign il_o_err     = (state_q == StErr);
    // Tied to the state so the enable drops as soon as a restart leaves DONE.
    assign il_o_core_ce = (state_q == StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: per-byte stream model predicts writes and status each cycle.
module tb_imem_loader;

    localparam int unsigned DEPTH = 1024;

    typedef logic [7:0] bq_t[$];

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  bin   = 8'h00;
    logic        ready, wr_en, busy, err, ce;
    logic [31:0] addr, data;

    imem_loader #(
        .IWIDTH  (32),
        .PC_WIDTH(32),
        .DEPTH   (DEPTH)
    ) dut (
        .il_clk      (clk),
        .il_rst      (rst_n),
        .il_i_start  (start),
        .il_i_valid  (valid),
        .il_i_byte   (bin),
        .il_o_ready  (ready),
        .il_o_wr_en  (wr_en),
        .il_o_addr   (addr),
        .il_o_data   (data),
        .il_o_busy   (busy),
        .il_o_err    (err),
        .il_o_core_ce(ce)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    logic        exp_busy = 1'b0, exp_ce = 1'b0, exp_err = 1'b0, exp_wr = 1'b0;
    logic [31:0] exp_addr = '0, exp_data = '0;
    logic [31:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    logic [7:0]  model_xor;
    logic [31:0] wq[$];
    bq_t         s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(ready), 32'(exp_busy));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("core_ce", 32'(ce), 32'(exp_ce));
            chk("err", 32'(err), 32'(exp_err));
            chk("wr_en", 32'(wr_en), 32'(exp_wr));
            chk("addr", addr, exp_addr);
            chk("data", data, exp_data);
            if (wr_en === 1'b1) begin
                wlog_a.push_back(addr);
                wlog_d.push_back(data);
            end
        end
    end

    task automatic build(input logic [31:0] words[$], input bit good, output bq_t st);
        logic [7:0] x;
        x  = 8'h00;
        st = {};
        st.push_back(8'(words.size() >> 8));
        st.push_back(8'(words.size()));
        foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) begin
                st.push_back(words[i][8*k +: 8]);
                x ^= words[i][8*k +: 8];
            end
        end
        st.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            valid = 1'b1;
            bin   = 8'($urandom);
            @(posedge clk);
            #1;
            exp_wr = 1'b0;
        end
        valid = 1'b0;
    endtask

    // Drives one load; abort_at >= 0 stops after that many accepted bytes (caller resets).
    task automatic run_load(input bq_t st, input int gap_pct, input int abort_at);
        int         p;
        int         n;
        int         cyc;
        bit         fin;
        logic [7:0] xr;
        p   = 0;
        n   = 0;
        cyc = 0;
        fin = 1'b0;
        xr  = 8'h00;
        wlog_a.delete();
        wlog_d.delete();
        @(posedge clk);
        #1;
        start = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        exp_busy = 1'b1;
        exp_ce   = 1'b0;
        exp_err  = 1'b0;
        while (!fin) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                valid = 1'b0;
                bin   = 8'($urandom);
            end else begin
                valid = 1'b1;
                bin   = st[p];
            end
            start = ($urandom_range(15) == 0);
            @(posedge clk);
            #1;
            exp_wr = 1'b0;
            cyc++;
            if (valid) begin
                if (p == 0) begin
                    n = int'(st[0]) << 8;
                end else if (p == 1) begin
                    n += int'(st[1]);
                    if (n > int'(DEPTH)) begin
                        exp_busy = 1'b0;
                        exp_err  = 1'b1;
                        fin      = 1'b1;
                    end
                end else if (p < 2 + 4 * n) begin
                    xr ^= st[p];
                    if ((p - 2) % 4 == 3) begin
                        exp_wr   = 1'b1;
                        exp_addr = 32'(4 * ((p - 2) / 4));
                        exp_data = {st[p-3], st[p-2], st[p-1], st[p]};
                    end
                end else begin
                    exp_busy = 1'b0;
                    if (st[p] == xr) exp_ce = 1'b1;
                    else exp_err = 1'b1;
                    fin = 1'b1;
                end
                p++;
                if (p == abort_at) fin = 1'b1;
            end
            if (cyc > 8 * st.size() + 200) begin
                total++;
                bad++;
                $display("FAIL load_timeout got=%0d want=done t=%0t", cyc, $time);
                fin = 1'b1;
            end
        end
        start     = 1'b0;
        valid     = 1'b0;
        model_xor = xr;
        if (abort_at < 0) idle(3);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        exp_busy = 1'b0;
        exp_ce   = 1'b0;
        exp_err  = 1'b0;
        exp_wr   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        repeat (4) begin
            valid = 1'($urandom);
            start = 1'($urandom);
            bin   = 8'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_core_ce", 32'(ce), 32'd0);
        valid = 1'b0;
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_t2_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wlog_a.size()), 32'd2);
        if (wlog_a.size() >= 2) begin
            chk({tag, "_a0"}, wlog_a[0], 32'h0000_0000);
            chk({tag, "_d0"}, wlog_d[0], 32'h2008_0005);
            chk({tag, "_a1"}, wlog_a[1], 32'h0000_0004);
            chk({tag, "_d1"}, wlog_d[1], 32'h2009_000A);
        end
    endtask

    initial begin
        bq_t t2;
        int  nw;
        #1;
        rst_n  = 1'b0;
        chk_en = 1'b1;
        do_reset();

        // Good two-word load.
        wq = '{32'h2008_0005, 32'h2009_000A};
        build(wq, 1'b1, t2);
        chk("t2_chk_byte", 32'(t2[10]), 32'h0E);
        run_load(t2, 0, -1);
        chk("t2_model_xor", 32'(model_xor), 32'h0E);
        check_t2_writes("t2");
        chk("t2_ce", 32'(ce), 32'd1);
        chk("t2_err", 32'(err), 32'd0);

        // Bad checksum.
        s     = t2;
        s[10] = 8'h0F;
        run_load(s, 0, -1);
        check_t2_writes("t3");
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_ce", 32'(ce), 32'd0);

        // Empty image.
        s = '{8'h00, 8'h00, 8'h00};
        run_load(s, 0, -1);
        chk("t4_nwr", 32'(wlog_a.size()), 32'd0);
        chk("t4_ce", 32'(ce), 32'd1);

        // Oversize count.
        s = '{8'h04, 8'h01};
        run_load(s, 0, -1);
        chk("t5_nwr", 32'(wlog_a.size()), 32'd0);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_ready", 32'(ready), 32'd0);

        // Gaps, then reset mid-load, then a clean reload.
        run_load(t2, 40, -1);
        check_t2_writes("t6gap");
        run_load(t2, 30, 5);
        do_reset();
        chk("t6_abort_nwr", 32'(wlog_a.size()), 32'd0);
        chk("t6_abort_addr", addr, 32'd0);
        run_load(t2, 0, -1);
        check_t2_writes("t6re");
        chk("t6re_ce", 32'(ce), 32'd1);

        for (int i = 0; i < 20; i++) begin
            wq.delete();
            nw = int'($urandom_range(6));
            for (int j = 0; j < nw; j++) wq.push_back($urandom);
            build(wq, ($urandom_range(3) != 0), s);
            run_load(s, int'($urandom_range(50)), -1);
            chk("rnd_nwr", 32'(wlog_a.size()), 32'(nw));
        end

        // Largest legal image.
        wq.delete();
        for (int j = 0; j < int'(DEPTH); j++) wq.push_back($urandom);
        build(wq, 1'b1, s);
        run_load(s, 10, -1);
        chk("full_nwr", 32'(wlog_a.size()), 32'(DEPTH));
        chk("full_last_addr", (wlog_a.size() > 0) ? wlog_a[$] : 32'hFFFF_FFFF, 32'(4 * (DEPTH - 1)));
        chk("full_ce", 32'(ce), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
